// File: rtl/ahbl_excl_monitor_pkg.sv
// Shared AHB-Lite definitions for the exclusive-access monitor: HTRANS
// encodings and the width of the reservation-granule address compare.
package ahbl_excl_monitor_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Number of address bits above the granule offset that take part in a match.
    function automatic int granule_w(input int w_addr, input int granule_log2);
        return w_addr - granule_log2;
    endfunction

endpackage

// File: rtl/ahbl_excl_resv_slot.sv
// One reservation slot: a valid bit plus the reserved granule address,
// with set, clear-on-matching-write and a combinational match output.
module ahbl_excl_resv_slot #(
    parameter int GW = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [GW-1:0] set_granule,
    input  logic          clr_en,
    input  logic [GW-1:0] clr_granule,
    input  logic [GW-1:0] cmp_granule,
    output logic          match
);

    logic          valid_q;
    logic [GW-1:0] granule_q;
    logic          clr_hit;
    logic          set_killed;

    assign clr_hit    = clr_en && valid_q && (granule_q == clr_granule);
    // A write to the granule being reserved on the same edge wins over the set.
    assign set_killed = clr_en && (set_granule == clr_granule);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (set_en) begin
            valid_q <= !set_killed;
        end else if (clr_hit) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) begin
            granule_q <= set_granule;
        end
    end

    assign match = valid_q && (granule_q == cmp_granule);

endmodule

// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor placed between a crossbar port and a memory
// slave: tracks one reservation per master and suppresses failing exclusive writes.
module ahbl_excl_monitor
    import ahbl_excl_monitor_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int GRANULE_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int GW = granule_w(W_ADDR, GRANULE_LOG2);

    logic                 accept;
    logic [GW-1:0]        addr_granule;
    logic [N_MASTERS-1:0] slot_match;
    logic                 excl_pass;
    logic                 excl_wr;
    logic                 wr_fail;
    logic                 wr_clear;
    logic                 set_en;

    logic                 suppressed;
    logic                 rd_excl;
    logic                 wr_excl_ok;
    logic [7:0]           rd_master;
    logic [GW-1:0]        rd_granule;

    assign accept       = src_hready && src_htrans[1];
    assign addr_granule = src_haddr[W_ADDR-1:GRANULE_LOG2];
    assign excl_wr      = accept && src_hexcl && src_hwrite;
    assign wr_fail      = excl_wr && !excl_pass;
    assign wr_clear     = accept && src_hwrite && !wr_fail;

    // Masters without a slot never match, so their exclusive writes always fail.
    always_comb begin
        excl_pass = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (int'(src_hmaster) == i && slot_match[i]) begin
                excl_pass = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suppressed <= 1'b0;
            rd_excl    <= 1'b0;
            wr_excl_ok <= 1'b0;
            rd_master  <= '0;
            rd_granule <= '0;
        end else if (src_hready) begin
            suppressed <= wr_fail;
            rd_excl    <= accept && src_hexcl && !src_hwrite;
            wr_excl_ok <= excl_wr && excl_pass;
            rd_master  <= src_hmaster;
            rd_granule <= addr_granule;
        end
    end

    assign set_en = rd_excl && dst_hready_resp && !dst_hresp && (int'(rd_master) < N_MASTERS);

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
        ahbl_excl_resv_slot #(
            .GW (GW)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .set_en      (set_en && (int'(rd_master) == i)),
            .set_granule (rd_granule),
            .clr_en      (wr_clear),
            .clr_granule (addr_granule),
            .cmp_granule (addr_granule),
            .match       (slot_match[i])
        );
    end

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = wr_fail ? HTRANS_IDLE : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;

    // A suppressed write answers OKAY locally in one cycle; the slave never saw it.
    assign src_hready_resp = suppressed || dst_hready_resp;
    assign src_hresp       = !suppressed && dst_hresp;
    assign src_hrdata      = suppressed ? '0 : dst_hrdata;
    assign src_hexokay     = !suppressed && (rd_excl || wr_excl_ok);

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Randomized bench for ahbl_excl_monitor: a behavioural memory slave plus a
// reservation/memory reference model that predicts every response.
module tb_ahbl_excl_monitor;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
    logic [31:0] src_haddr, src_hwdata, src_hrdata;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize, src_hburst;
    logic [3:0]  src_hprot;
    logic [7:0]  src_hmaster;
    logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
    logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    assign src_hready = src_hready_resp;

    ahbl_excl_monitor #(
        .N_MASTERS(N), .W_ADDR(32), .W_DATA(32), .GRANULE_LOG2(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
        .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
    );

    // Memory slave: wait states and error responses set per transfer by the stimulus.
    logic        pend = 1'b0;
    logic        pend_wr = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_left = 0;
    int          cfg_stall = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] slv_mem [0:4095];

    always @(posedge clk) begin
        if (pend && pend_wr && dst_hready_resp && !dst_hresp)
            slv_mem[pend_addr[13:2]] <= dst_hwdata;
        if (dst_hready) begin
            pend      <= dst_htrans[1];
            pend_addr <= dst_haddr;
            pend_wr   <= dst_hwrite;
            wait_left <= cfg_stall;
        end else if (wait_left > 0) begin
            wait_left <= wait_left - 1;
        end
    end

    assign dst_hready_resp = !pend || (wait_left == 0);
    assign dst_hresp       = pend && cfg_err;
    assign dst_hrdata      = (pend && !pend_wr) ? slv_mem[pend_addr[13:2]] : '0;

    // Reference model: one reservation per master, granule = addr >> 3.
    bit          ref_v [N];
    logic [28:0] ref_g [N];
    logic [31:0] ref_mem [0:4095];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_pass(input logic [7:0] m, input logic [31:0] a);
        if (int'(m) >= N) return 1'b0;
        return ref_v[m] && (ref_g[m] == a[31:3]);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < N; i++)
            if (ref_v[i] && ref_g[i] == a[31:3]) ref_v[i] = 1'b0;
        ref_mem[a[13:2]] = d;
    endfunction

    task automatic bus_idle();
        src_htrans = 2'b00; src_hexcl = 1'b0; src_hwrite = 1'b0;
    endtask

    task automatic drive_addr(input logic [7:0] m, input logic [31:0] a, input logic wr, input logic ex);
        src_htrans    = 2'b10;
        src_haddr     = a;
        src_hwrite    = wr;
        src_hexcl     = ex;
        src_hmaster   = m;
        src_hsize     = 3'($urandom_range(0, 2));
        src_hburst    = 3'($urandom_range(0, 7));
        src_hprot     = 4'($urandom);
        src_hmastlock = 1'($urandom);
    endtask

    // One complete non-overlapped transfer, checked against the model.
    task automatic xfer(input logic [7:0] m, input logic [31:0] a, input logic wr, input logic ex,
                        input logic [31:0] wd, input int stall, input logic err, input string tag);
        bit fail;
        int cnt;
        @(negedge clk);
        chk({tag, "/idle_exokay"}, 32'(src_hexokay), 0);
        fail = ex && wr && !ref_pass(m, a);
        cfg_stall = stall;
        cfg_err   = err && !wr;
        drive_addr(m, a, wr, ex);
        #1;
        chk({tag, "/htrans"}, 32'(dst_htrans), fail ? 0 : 2);
        chk({tag, "/haddr"}, dst_haddr, a);
        chk({tag, "/ctrl"}, 32'({dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock}),
            32'({wr, src_hsize, src_hburst, src_hprot, src_hmastlock}));
        @(negedge clk);
        bus_idle();
        src_hwdata = wd;
        cnt = 0;
        while (!src_hready_resp && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "/wait"}, cnt, fail ? 0 : stall);
        chk({tag, "/exokay"}, 32'(src_hexokay), (ex && !fail) ? 1 : 0);
        chk({tag, "/hresp"}, 32'(src_hresp), (!wr && err) ? 1 : 0);
        if (!wr && !err) chk({tag, "/rdata"}, src_hrdata, ref_mem[a[13:2]]);
        if (wr && !fail) ref_write(a, wd);
        if (!wr && ex && !err && int'(m) < N) begin
            ref_v[m] = 1'b1;
            ref_g[m] = a[31:3];
        end
    endtask

    initial begin
        logic [31:0] bases [4];
        int mism;
        int cnt;
        bases[0] = 32'h1000; bases[1] = 32'h1008; bases[2] = 32'h2000; bases[3] = 32'h3000;
        for (int i = 0; i < 4096; i++) begin
            slv_mem[i] = 32'(i) * 32'h01010101;
            ref_mem[i] = 32'(i) * 32'h01010101;
        end
        for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
        rst_n = 1'b0;
        src_haddr = '0; src_hwdata = '0; src_hmaster = '0; src_hsize = '0;
        src_hburst = '0; src_hprot = '0; src_hmastlock = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("reset/hready_resp", 32'(src_hready_resp), 1);
        chk("reset/hresp", 32'(src_hresp), 0);
        chk("reset/exokay", 32'(src_hexokay), 0);
        chk("reset/hrdata", src_hrdata, 0);
        rst_n = 1'b1;

        // Reservation then exclusive write within the same 8-byte granule.
        xfer(0, 32'h1000, 0, 1, 0, 0, 0, "excl_rd_a");
        xfer(0, 32'h1004, 1, 1, 32'hA5A5_0001, 1, 0, "excl_wr_pass");
        @(negedge clk);
        chk("excl_wr_pass/mem", slv_mem[32'h1004 >> 2], 32'hA5A5_0001);
        xfer(0, 32'h1000, 1, 1, 32'hBAD0_0001, 0, 0, "excl_wr_after_clear");

        // Another master's write kills the reservation.
        xfer(0, 32'h1000, 0, 1, 0, 0, 0, "excl_rd_b");
        xfer(1, 32'h1000, 1, 0, 32'h1111_1111, 0, 0, "norm_wr_m1");
        xfer(0, 32'h1000, 1, 1, 32'hDEAD_BEEF, 2, 0, "excl_wr_killed");
        @(negedge clk);
        chk("excl_wr_killed/mem", slv_mem[32'h1000 >> 2], 32'h1111_1111);

        xfer(1, 32'h1800, 1, 1, 32'hBAD0_0002, 0, 0, "excl_wr_no_resv");
        xfer(0, 32'h2000, 0, 1, 0, 1, 1, "excl_rd_err");
        xfer(0, 32'h2000, 1, 1, 32'hBAD0_0003, 0, 0, "excl_wr_after_err");
        xfer(5, 32'h2400, 0, 1, 0, 0, 0, "excl_rd_m5");
        xfer(5, 32'h2400, 1, 1, 32'hBAD0_0004, 0, 0, "excl_wr_m5");

        // Back-to-back: read completes on the same edge a write to its granule is accepted.
        @(negedge clk);
        cfg_stall = 0; cfg_err = 1'b0;
        drive_addr(0, 32'h3000, 0, 1);
        @(negedge clk);
        chk("pipe/rd_ready", 32'(src_hready_resp), 1);
        chk("pipe/rd_exokay", 32'(src_hexokay), 1);
        chk("pipe/rd_data", src_hrdata, ref_mem[32'h3000 >> 2]);
        drive_addr(1, 32'h3000, 1, 0);
        @(negedge clk);
        bus_idle();
        src_hwdata = 32'h3333_3333;
        chk("pipe/wr_ready", 32'(src_hready_resp), 1);
        chk("pipe/wr_exokay", 32'(src_hexokay), 0);
        ref_v[0] = 1'b1;
        ref_g[0] = 29'(32'h3000 >> 3);
        ref_write(32'h3000, 32'h3333_3333);
        xfer(0, 32'h3000, 1, 1, 32'hBAD0_0005, 0, 0, "pipe_excl_wr");

        // Reset in the middle of a stalled exclusive read.
        @(negedge clk);
        cfg_stall = 6; cfg_err = 1'b0;
        drive_addr(0, 32'h2800, 0, 1);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        chk("rst_mid/pre_exokay", 32'(src_hexokay), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/exokay", 32'(src_hexokay), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
        cnt = 0;
        while (!src_hready_resp && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_mid/drain_bound", 32'(cnt < 50), 1);
        xfer(0, 32'h2800, 1, 1, 32'hBAD0_0006, 0, 0, "rst_mid_excl_wr");

        for (int k = 0; k < 250; k++) begin
            logic [7:0]  m;
            logic [31:0] a;
            logic        wr, ex;
            m  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 1)) : 8'd5;
            a  = bases[$urandom_range(0, 3)] + ($urandom_range(0, 1) * 4);
            wr = 1'($urandom);
            ex = ($urandom_range(0, 3) != 0);
            xfer(m, a, wr, ex, $urandom, $urandom_range(0, 2), !wr && ($urandom_range(0, 7) == 0),
                 $sformatf("rnd%0d", k));
        end

        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 4096; i++)
            if (slv_mem[i] !== ref_mem[i]) mism++;
        chk("final/mem_mismatches", mism, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ahbl_excl_monitor.md
AHBL_EXCL_MONITOR -- requirements
Module: ahbl_excl_monitor

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2: number of reservation slots, indexed by hmaster.
REQ-002 SHALL have parameter W_ADDR, default 32: address width.
REQ-003 SHALL have parameter W_DATA, default 32: data width.
REQ-004 SHALL have parameter GRANULE_LOG2, default 3: reservation granule is 2^GRANULE_LOG2 bytes; haddr[W_ADDR-1:GRANULE_LOG2] is compared.
REQ-005 SHALL have these ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have these slave-side ports, fed by one crossbar destination port: src_hready in 1; src_hready_resp out 1; src_hresp out 1; src_haddr in W_ADDR; src_hwrite in 1; src_htrans in 2; src_hsize in 3; src_hburst in 3; src_hprot in 4; src_hmastlock in 1; src_hwdata in W_DATA; src_hrdata out W_DATA; src_hexcl in 1; src_hmaster in 8; src_hexokay out 1.
REQ-007 SHALL have these master-side ports, to the memory slave: dst_hready out 1; dst_hready_resp in 1; dst_hresp in 1; dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata out (same widths as src); dst_hrdata in W_DATA.

Function
REQ-008 SHALL accept an address phase when src_hready and src_htrans[1] are both 1.
REQ-009 SHALL forward all address-phase signals src->dst combinationally, with dst_hready = src_hready, except when an exclusive write is suppressed.
REQ-010 SHALL keep per slot a valid bit and a granule address; a slot matches when valid and its granule equals src_haddr[W_ADDR-1:GRANULE_LOG2].
REQ-011 SHALL decide an exclusive write (hexcl=1, hwrite=1) as passing only if src_hmaster < N_MASTERS and slot[src_hmaster] matches; the decision is combinational in the address phase.
REQ-012 SHALL, for a failing exclusive write, drive dst_htrans=IDLE (2'b00) for that cycle, so the write never reaches memory.
REQ-013 SHALL register a one-bit suppressed flag for the data phase; while it is set: src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0, and dst response inputs are ignored.
REQ-014 SHALL, for a passing exclusive write, drive src_hexokay=1 throughout its data phase.
REQ-015 SHALL, on every accepted write (exclusive-pass or non-exclusive, any master), clear every slot matching the write granule at the accepting edge.
REQ-016 SHALL register the data-phase context of an exclusive read: exclusive flag, master, granule.
REQ-017 SHALL, for an exclusive read, drive src_hexokay=1 in its data phase.
REQ-018 SHALL, when an exclusive read completes (dst_hready_resp=1 and dst_hresp=0), set slot[master] valid with the read granule.
REQ-019 SHALL not set any reservation for an exclusive read with an ERROR response or with master >= N_MASTERS.
REQ-020 SHALL hold src_hexokay=0 for non-exclusive transfers and in idle cycles.
REQ-021 SHALL let a clear take precedence over a set on the same edge when a reservation set (REQ-018) and a write clear (REQ-015) target the same slot and granule.
REQ-022 SHALL hold at most one reservation per master; a new exclusive read overwrites that master's slot.
REQ-023 SHALL otherwise pass the data phase through: src_hready_resp=dst_hready_resp, src_hresp=dst_hresp, src_hrdata=dst_hrdata, dst_hwdata=src_hwdata.
REQ-024 SHALL add zero latency to passed transfers; a suppressed write completes in exactly one data-phase cycle.

Reset
REQ-025 SHALL, while rst_n=0, clear all slot valid bits, the suppressed flag and the data-phase context, regardless of any transfer in progress.
REQ-026 SHALL, after reset, give src_hready_resp=1, src_hresp=0, src_hexokay=0, src_hrdata=0.

Structure
REQ-027 SHALL take the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and the granule-compare width from a shared AHB-Lite definitions package.
REQ-028 SHALL instantiate one sub-module, ahbl_excl_resv_slot (valid + granule register with set/clear/match), N_MASTERS times.

Verification
REQ-029 SHALL cover: master 0 exclusive read 0x1000, then exclusive write 0x1004 (GRANULE_LOG2=3) -> read hexokay=1, write reaches dst, hexokay=1, slot 0 cleared.
REQ-030 SHALL cover: master 0 exclusive read 0x1000, master 1 normal write 0x1000, master 0 exclusive write 0x1000 -> dst_htrans=IDLE for that write, src_hready_resp=1, hexokay=0, memory unchanged.
REQ-031 SHALL cover: exclusive write by master 1 with no prior reservation -> suppressed, one-cycle OKAY, hexokay=0.
REQ-032 SHALL cover: exclusive read 0x2000 answered with dst_hresp=1 -> no reservation, so a following exclusive write to 0x2000 fails.
REQ-033 SHALL cover: exclusive read by hmaster=5 with N_MASTERS=2 -> no slot set, subsequent exclusive write fails.
REQ-034 SHALL cover: rst_n pulsed low between exclusive read and exclusive write with dst_hready_resp=0 stalls -> all slots cleared, write suppressed with hexokay=0.
